// File: rtl/handshake_pkg.sv
// handshake_pkg: state encoding shared by the handshake controllers.
package handshake_pkg;
    typedef enum logic [1:0] {ARB, ISSUE, WAIT_DONE} arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr_i.
//   req_i  request vector
//   ptr_i  highest-priority index for this pick
//   gnt_o  one-hot grant
//   idx_o  binary index of the grant
//   any_o  a grant exists
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic                 any_o
);
    always_comb begin
        int k;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr_i) + i) % NUM_REQ;
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IDX_WIDTH'(k);
            end
        end
    end
endmodule

// File: rtl/handshake_src_arbiter.sv
// handshake_src_arbiter: shares one 4-phase handshake source FSM among NUM_REQ requesters.
//   req_valid_i/req_data_i/req_ready_o  per-requester valid/ready word ports
//   hs_valid_o/hs_data_o/hs_id_o        registered launch pulse, payload and winner ID
//   hs_busy_i                           busy from the source FSM
//   timeout_o/timeout_clr_i             sticky stall flag and its clear
module handshake_src_arbiter
    import handshake_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          hs_valid_o,
    output logic [DATA_WIDTH-1:0]         hs_data_o,
    output logic [ID_WIDTH-1:0]           hs_id_o,
    input  logic                          hs_busy_i,
    output logic                          timeout_o,
    input  logic                          timeout_clr_i
);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e            state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d, hs_id_q, hs_id_d, win_idx;
    logic [DATA_WIDTH-1:0] hs_data_q, hs_data_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0]    win_gnt;
    logic                  hs_valid_q, hs_valid_d, timeout_q, timeout_d;
    logic                  any_req, grant_en, to_set;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .IDX_WIDTH(ID_WIDTH)
    ) u_rr (
        .req_i(req_valid_i),
        .ptr_i(ptr_q),
        .gnt_o(win_gnt),
        .idx_o(win_idx),
        .any_o(any_req)
    );

    // Busy seen in ARB means someone else owns the source FSM: hold off.
    // Ready is also masked while reset is asserted.
    assign grant_en    = reset_ni && state_q == ARB && !hs_busy_i && any_req;
    assign req_ready_o = grant_en ? win_gnt : '0;
    assign to_set      = state_q == WAIT_DONE && hs_busy_i && cnt_q == CW'(TIMEOUT - 1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hs_valid_d = 1'b0;
        hs_data_d  = hs_data_q;
        hs_id_d    = hs_id_q;
        cnt_d      = '0;
        // Set beats clear when both land in the same cycle.
        timeout_d  = to_set | (timeout_q & ~timeout_clr_i);
        case (state_q)
            ARB: begin
                if (grant_en) begin
                    state_d    = ISSUE;
                    hs_valid_d = 1'b1;
                    hs_data_d  = req_data_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
                    hs_id_d    = win_idx;
                    ptr_d      = win_idx == ID_WIDTH'(NUM_REQ - 1) ? '0 : win_idx + 1'b1;
                end
            end
            ISSUE: state_d = WAIT_DONE;
            WAIT_DONE: begin
                cnt_d = cnt_q == CW'(TIMEOUT) ? cnt_q : cnt_q + 1'b1;
                if (!hs_busy_i) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            hs_valid_q <= 1'b0;
            hs_data_q  <= '0;
            hs_id_q    <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hs_valid_q <= hs_valid_d;
            hs_data_q  <= hs_data_d;
            hs_id_q    <= hs_id_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign hs_valid_o = hs_valid_q;
    assign hs_data_o  = hs_data_q;
    assign hs_id_o    = hs_id_q;
    assign timeout_o  = timeout_q;
endmodule

// File: tb/tb_handshake_src_arbiter.sv
// tb_handshake_src_arbiter: directed bench for handshake_src_arbiter.
module tb_handshake_src_arbiter;
    localparam logic [31:0] D0 = 32'hC0C0_0001;
    localparam logic [31:0] D1 = 32'h1111_2222;
    localparam logic [31:0] D2 = 32'hDEAD_BEEF;
    localparam logic [31:0] D3 = 32'h3333_4444;

    logic         clk_i = 1'b0;
    logic         reset_ni;
    logic [3:0]   req_valid_i;
    logic [127:0] req_data_i;
    logic [3:0]   req_ready_o;
    logic         hs_valid_o;
    logic [31:0]  hs_data_o;
    logic [1:0]   hs_id_o;
    logic         hs_busy_i;
    logic         timeout_o;
    logic         timeout_clr_i;
    logic         busy_force;
    logic [31:0]  dat [4];
    int           bcnt;
    int           checks = 0;
    int           errors = 0;
    int           n;

    always #5 clk_i = ~clk_i;

    // Source FSM model: busy rises the cycle after the launch pulse and lasts 6 cycles.
    always @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) bcnt <= 0;
        else if (hs_valid_o) bcnt <= 6;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end
    assign hs_busy_i = busy_force | (bcnt > 0);

    handshake_src_arbiter #(
        .NUM_REQ   (4),
        .DATA_WIDTH(32),
        .ID_WIDTH  (2),
        .TIMEOUT   (8)
    ) dut (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .hs_valid_o   (hs_valid_o),
        .hs_data_o    (hs_data_o),
        .hs_id_o      (hs_id_o),
        .hs_busy_i    (hs_busy_i),
        .timeout_o    (timeout_o),
        .timeout_clr_i(timeout_clr_i)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for a grant, then checks accept, the one-cycle launch and the hold.
    task automatic xfer(input logic [3:0] g, input logic [1:0] id, input logic [31:0] d,
                        input bit drop, input bit hold, output int waited);
        waited = 0;
        while (req_ready_o == 4'b0 && waited < 40) begin
            chk("no_valid_while_waiting", {63'b0, hs_valid_o}, 64'd0);
            step();
            waited++;
        end
        chk("grant_ready", {60'b0, req_ready_o}, {60'b0, g});
        step();
        if (drop) req_valid_i = req_valid_i & ~g;
        if (hold) busy_force = 1'b1;
        chk("issue_valid", {63'b0, hs_valid_o}, 64'd1);
        chk("issue_data", {32'b0, hs_data_o}, {32'b0, d});
        chk("issue_id", {62'b0, hs_id_o}, {62'b0, id});
        chk("issue_ready", {60'b0, req_ready_o}, 64'd0);
        step();
        chk("pulse_one_cycle", {63'b0, hs_valid_o}, 64'd0);
        chk("hold_data", {32'b0, hs_data_o}, {32'b0, d});
        chk("hold_id", {62'b0, hs_id_o}, {62'b0, id});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        dat[0] = D0; dat[1] = D1; dat[2] = D2; dat[3] = D3;
        req_data_i    = {D3, D2, D1, D0};
        req_valid_i   = 4'hF;
        busy_force    = 1'b0;
        timeout_clr_i = 1'b0;
        reset_ni      = 1'b0;
        step();
        step();
        chk("rst_valid", {63'b0, hs_valid_o}, 64'd0);
        chk("rst_data", {32'b0, hs_data_o}, 64'd0);
        chk("rst_id", {62'b0, hs_id_o}, 64'd0);
        chk("rst_timeout", {63'b0, timeout_o}, 64'd0);
        chk("rst_ready", {60'b0, req_ready_o}, 64'd0);
        reset_ni    = 1'b1;
        req_valid_i = 4'b0000;
        #1;
        chk("idle_ready", {60'b0, req_ready_o}, 64'd0);

        req_valid_i = 4'b0100;
        #1;
        xfer(4'b0100, 2'd2, D2, 1'b1, 1'b0, n);
        chk("first_latency", n, 64'd0);
        req_valid_i = 4'b1000;
        xfer(4'b1000, 2'd3, D3, 1'b1, 1'b0, n);
        chk("wait_busy_fall", n, 64'd7);

        req_valid_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            xfer(4'b0001 << (i % 4), 2'(i % 4), dat[i % 4], 1'b0, 1'b0, n);
            chk("rr_gap", n, 64'd7);
        end

        req_valid_i = 4'b0001;
        xfer(4'b0001, 2'd0, D0, 1'b1, 1'b0, n);
        req_valid_i = 4'b1001;
        xfer(4'b1000, 2'd3, D3, 1'b0, 1'b0, n);
        xfer(4'b0001, 2'd0, D0, 1'b1, 1'b0, n);
        req_valid_i = 4'b0000;

        repeat (8) step();
        busy_force  = 1'b1;
        req_valid_i = 4'b0010;
        #1;
        chk("busy_in_arb_ready", {60'b0, req_ready_o}, 64'd0);
        repeat (3) step();
        chk("busy_in_arb_ready_later", {60'b0, req_ready_o}, 64'd0);
        chk("busy_in_arb_valid", {63'b0, hs_valid_o}, 64'd0);
        busy_force = 1'b0;
        #1;

        xfer(4'b0010, 2'd1, D1, 1'b1, 1'b1, n);
        for (int i = 0; i < 8; i++) begin
            chk("timeout_low", {63'b0, timeout_o}, 64'd0);
            step();
        end
        chk("timeout_rise", {63'b0, timeout_o}, 64'd1);
        step();
        step();
        chk("timeout_sticky", {63'b0, timeout_o}, 64'd1);

        busy_force  = 1'b0;
        req_valid_i = 4'b0100;
        xfer(4'b0100, 2'd2, D2, 1'b1, 1'b1, n);
        chk("timeout_held_next", {63'b0, timeout_o}, 64'd1);
        repeat (7) step();
        timeout_clr_i = 1'b1;
        step();
        chk("clear_and_set", {63'b0, timeout_o}, 64'd1);
        step();
        chk("clear", {63'b0, timeout_o}, 64'd0);
        timeout_clr_i = 1'b0;

        req_valid_i = 4'hF;
        reset_ni    = 1'b0;
        #1;
        chk("midrst_valid", {63'b0, hs_valid_o}, 64'd0);
        chk("midrst_data", {32'b0, hs_data_o}, 64'd0);
        chk("midrst_id", {62'b0, hs_id_o}, 64'd0);
        chk("midrst_ready", {60'b0, req_ready_o}, 64'd0);
        busy_force = 1'b0;
        step();
        reset_ni = 1'b1;
        #1;
        xfer(4'b0001, 2'd0, D0, 1'b1, 1'b0, n);
        chk("post_reset_latency", n, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/handshake_src_arbiter.md
Name: handshake_src_arbiter

Overview:
- Shares one handshake source FSM (4-phase req/ack CDC launcher) among NUM_REQ requesters in the source clock domain.
- Accepts words on per-requester valid/ready ports and picks a winner round-robin.
- Issues the winner as a one-cycle valid pulse with data to the source FSM, then waits for the FSM's busy to fall before the next grant.
- Tags each transfer with the winner's ID and flags transfers that stall too long.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 32, payload width per requester.
- ID_WIDTH, $clog2(NUM_REQ), width of the requester ID tag.
- TIMEOUT, 1024, busy cycles per transfer before timeout_o sets (>=2).

Ports:
- clk_i  input  1  clock.
- reset_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  NUM_REQ  per-requester word valid.
- req_data_i  input  NUM_REQ*DATA_WIDTH  packed payloads; requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  output  NUM_REQ  one-hot accept; combinational.
- hs_valid_o  output  1  launch pulse to the source FSM valid input; registered.
- hs_data_o  output  DATA_WIDTH  payload to the source FSM data input; registered.
- hs_id_o  output  ID_WIDTH  ID of the requester in flight; registered.
- hs_busy_i  input  1  source FSM busy output.
- timeout_o  output  1  sticky stall flag.
- timeout_clr_i  input  1  synchronous clear of timeout_o.

Behaviour:
- Reset is asynchronous, active-low reset_ni; clock is clk_i.
- Reset values:
  - state = ARB.
  - hs_valid_o = 0, hs_data_o = 0, hs_id_o = 0.
  - timeout_o = 0.
  - Round-robin pointer = 0; timeout counter = 0.
- States: ARB, ISSUE, WAIT_DONE.
- ARB:
  - If hs_busy_i = 0 and any req_valid_i is set: the round-robin search from the pointer picks winner w.
  - req_ready_o[w] = 1 in the same cycle; the transfer completes when valid & ready are both high.
  - At the edge: hs_valid_o <= 1, hs_data_o <= req_data_i[w], hs_id_o <= w, pointer <= (w+1) mod NUM_REQ, go to ISSUE.
  - If hs_busy_i = 1 or no request: req_ready_o = 0; stay in ARB.
- ISSUE:
  - hs_valid_o is high for exactly this one cycle.
  - At the edge: hs_valid_o <= 0, go to WAIT_DONE.
  - req_ready_o = 0.
- WAIT_DONE:
  - Busy is registered in the source FSM, so hs_busy_i = 1 on entry.
  - Stay while hs_busy_i = 1; go to ARB when hs_busy_i = 0.
  - req_ready_o = 0; hs_data_o and hs_id_o are held stable.
- Throughput: at most one grant per transfer. The next grant can come in the first ARB cycle after busy falls.
- Latency: 1 cycle from accept to the hs_valid_o edge.
- Round-robin:
  - Search order is pointer, pointer+1, …, wrapping mod NUM_REQ.
  - The pointer only advances on a grant.
  - A continuously asserted requester is granted within NUM_REQ transfers.
- Requester rules:
  - Requesters must hold valid and data stable until ready.
  - Dropping valid before ready is legal; that word is not sent.
- Timeout counter:
  - Counts cycles in WAIT_DONE and cleared to 0 on entry.
  - Saturates at TIMEOUT.
  - timeout_o <= 1 when the count reaches TIMEOUT-1 while busy.
  - timeout_o stays set until timeout_clr_i. If clear and set happen in the same cycle, set wins.
  - The transfer is never aborted; the arbiter keeps waiting.
- Unexpected hs_busy_i = 1 in ARB: no grant. The block waits, which protects against an external user of the source FSM.
- Reset mid-transfer: all state returns to reset values. The source FSM shares the reset, so no transfer resumes.

Decomposition:
- Package handshake_pkg:
  - typedef enum logic [1:0] arb_state_e {ARB, ISSUE, WAIT_DONE}.
  - Shared with other handshake controllers.
- Sub-module rr_arbiter (NUM_REQ):
  - Combinational round-robin pick from a request vector and pointer.
  - Returns one-hot grant and binary index.
  - Reusable for a future destination-side scheduler.

Test Plan:
- Reset with req_valid_i = 4'b1111 → all outputs 0; no ready until reset_ni rises.
- Single requester 2, data 0xDEADBEEF, busy model 1 cycle after valid and low 6 cycles later:
  - req_ready_o = 4'b0100 in the accept cycle.
  - Next cycle: hs_valid_o = 1 for exactly one cycle, hs_data_o = 0xDEADBEEF, hs_id_o = 2.
  - Next grant only after busy falls.
- All four requesters valid continuously for 8 transfers → grant IDs 0,1,2,3,0,1,2,3; no valid pulses while busy.
- req_valid_i = 4'b1001 with pointer at 1 → grant 3, then 0.
- hs_busy_i held high with TIMEOUT = 8:
  - timeout_o rises after 8 WAIT_DONE cycles.
  - It stays high until timeout_clr_i; with clear and set in the same cycle, timeout_o stays 1.
- reset_ni asserted in WAIT_DONE → outputs reset asynchronously, state = ARB, pointer = 0; a fresh request is then granted normally.
